robo_ambiente: RTL

- Environment/world model that closes the loop around the wall-following robot controller.
- Consumes the controller's commands (avancar, girar, remover) and produces its sensor inputs (head, left, under, barrier) from a 2D grid map, the robot's position and its heading.
- Used in simulation and on FPGA to exercise the controller end-to-end.
- The map is loaded through a simple write port before a run.

---
 rtl/robo_pkg.sv | 58 +++++
 rtl/robo_ambiente_mapa.sv | 42 ++++
 rtl/robo_ambiente.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/robo_pkg.sv
// Shared cell and heading encodings for the robot environment model,
// plus the neighbour-offset helper used for the ahead and left lookups.
package robo_pkg;

    localparam int XY_W = 8;

    typedef enum logic [1:0] {
        CELL_FREE    = 2'b00,
        CELL_WALL    = 2'b01,
        CELL_BARRIER = 2'b10,
        CELL_TARGET  = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef struct packed {
        logic            oob;
        logic [XY_W-1:0] x;
        logic [XY_W-1:0] y;
    } xy_t;

    // Neighbour of (x, y) in direction d. There is no wrap-around: stepping
    // past either edge raises oob, and the caller treats that cell as wall.
    function automatic xy_t next_xy(input logic [XY_W-1:0] x,
                                    input logic [XY_W-1:0] y,
                                    input dir_t            d,
                                    input logic [XY_W-1:0] max_xy);
        xy_t r;
        r.oob = 1'b0;
        r.x   = x;
        r.y   = y;
        case (d)
            DIR_N: begin
                r.oob = (y == 8'd0);
                r.y   = y - 8'd1;
            end
            DIR_E: begin
                r.oob = (x == max_xy);
                r.x   = x + 8'd1;
            end
            DIR_S: begin
                r.oob = (y == max_xy);
                r.y   = y + 8'd1;
            end
            default: begin
                r.oob = (x == 8'd0);
                r.x   = x - 8'd1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/robo_ambiente_mapa.sv
// GRID x GRID map of 2-bit cell codes: one synchronous write port and
// three combinational read ports (current, ahead and left cells).
module robo_ambiente_mapa
    import robo_pkg::*;
#(
    parameter int GRID    = 8,
    parameter int COORD_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  cell_t              wr_cell,
    input  logic [COORD_W-1:0] cur_x,
    input  logic [COORD_W-1:0] cur_y,
    input  logic [COORD_W-1:0] ahead_x,
    input  logic [COORD_W-1:0] ahead_y,
    input  logic [COORD_W-1:0] left_x,
    input  logic [COORD_W-1:0] left_y,
    output cell_t              cur_cell,
    output cell_t              ahead_cell,
    output cell_t              left_cell
);

    cell_t cells [GRID*GRID];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < GRID*GRID; i++) begin
                cells[i] <= CELL_FREE;
            end
        end else if (wr_en) begin
            cells[{wr_y, wr_x}] <= wr_cell;
        end
    end

    assign cur_cell   = cells[{cur_y, cur_x}];
    assign ahead_cell = cells[{ahead_y, ahead_x}];
    assign left_cell  = cells[{left_y, left_x}];

endmodule

// File: rtl/robo_ambiente.sv
// World model for the wall-following controller: holds the robot pose and
// the map, executes its commands and produces its sensor inputs.
module robo_ambiente
    import robo_pkg::*;
#(
    parameter int GRID          = 8,
    parameter int COORD_W       = 3,
    parameter int REMOVE_CYCLES = 4,
    parameter int START_X       = 0,
    parameter int START_Y       = 0,
    parameter int START_DIR     = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_en,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    input  logic [1:0]         load_cell,
    input  logic               avancar,
    input  logic               girar,
    input  logic               remover,
    output logic               head,
    output logic               left,
    output logic               under,
    output logic               barrier,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [1:0]         dir,
    output logic               removing,
    output logic               collision,
    output logic               cmd_error,
    output logic [15:0]        step_count
);

    dir_t       heading;
    logic [3:0] rm_cnt;
    logic [3:0] rm_cnt_nxt;
    logic       clear_cell;
    logic       cmd_multi;
    logic       ahead_open;

    xy_t   ahead_xy;
    xy_t   left_xy;
    cell_t map_cur;
    cell_t map_ahead;
    cell_t map_left;
    cell_t ahead_cell;
    cell_t left_cell;

    logic               wr_en;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    cell_t              wr_cell;

    assign ahead_xy = next_xy(XY_W'(pos_x), XY_W'(pos_y), heading, XY_W'(GRID - 1));
    assign left_xy  = next_xy(XY_W'(pos_x), XY_W'(pos_y), dir_t'(heading + 2'd3),
                              XY_W'(GRID - 1));

    // Upper coordinate bits are always zero once oob is clear.
    logic unused_xy;
    assign unused_xy = ^{ahead_xy, left_xy};

    robo_ambiente_mapa #(
        .GRID    (GRID),
        .COORD_W (COORD_W)
    ) u_mapa (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_cell    (wr_cell),
        .cur_x      (pos_x),
        .cur_y      (pos_y),
        .ahead_x    (ahead_xy.x[COORD_W-1:0]),
        .ahead_y    (ahead_xy.y[COORD_W-1:0]),
        .left_x     (left_xy.x[COORD_W-1:0]),
        .left_y     (left_xy.y[COORD_W-1:0]),
        .cur_cell   (map_cur),
        .ahead_cell (map_ahead),
        .left_cell  (map_left)
    );

    assign ahead_cell = ahead_xy.oob ? CELL_WALL : map_ahead;
    assign left_cell  = left_xy.oob  ? CELL_WALL : map_left;

    assign head    = (ahead_cell == CELL_WALL);
    assign barrier = (ahead_cell == CELL_BARRIER);
    assign left    = (left_cell == CELL_WALL);
    assign under   = (map_cur == CELL_TARGET);
    assign dir     = heading;

    assign cmd_multi  = (avancar & girar) | (avancar & remover) | (girar & remover);
    assign ahead_open = (ahead_cell == CELL_FREE) || (ahead_cell == CELL_TARGET);

    // Removal only advances on uninterrupted remover cycles facing a barrier;
    // any other cycle drops the count back to zero.
    always_comb begin
        rm_cnt_nxt = 4'd0;
        clear_cell = 1'b0;
        if (!load_en && !cmd_multi && remover && (ahead_cell == CELL_BARRIER)) begin
            if (rm_cnt == 4'(REMOVE_CYCLES - 1)) begin
                clear_cell = 1'b1;
            end else begin
                rm_cnt_nxt = rm_cnt + 4'd1;
            end
        end
    end

    assign wr_en   = load_en | clear_cell;
    assign wr_x    = load_en ? load_x : ahead_xy.x[COORD_W-1:0];
    assign wr_y    = load_en ? load_y : ahead_xy.y[COORD_W-1:0];
    assign wr_cell = load_en ? cell_t'(load_cell) : CELL_FREE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos_x      <= COORD_W'(START_X);
            pos_y      <= COORD_W'(START_Y);
            heading    <= dir_t'(2'(START_DIR));
            rm_cnt     <= 4'd0;
            removing   <= 1'b0;
            collision  <= 1'b0;
            cmd_error  <= 1'b0;
            step_count <= 16'd0;
        end else begin
            rm_cnt   <= rm_cnt_nxt;
            removing <= (rm_cnt_nxt != 4'd0);
            if (!load_en) begin
                if (cmd_multi) begin
                    cmd_error <= 1'b1;
                end else if (avancar) begin
                    if (ahead_open) begin
                        pos_x <= ahead_xy.x[COORD_W-1:0];
                        pos_y <= ahead_xy.y[COORD_W-1:0];
                        if (step_count != 16'hFFFF) begin
                            step_count <= step_count + 16'd1;
                        end
                    end else begin
                        collision <= 1'b1;
                    end
                end else if (girar) begin
                    heading <= dir_t'(heading + 2'd1);
                end
            end
        end
    end

endmodule
